// File: rtl/pq_sched_pkg.sv
// -----------------------------------------------------------------------------
// pq_sched_pkg
//   Shared types for the systolic priority-queue operation scheduler.
//   sched_state_t : scheduler FSM states
//   pq_op_t       : operation kind driven to the comparison datapath
// -----------------------------------------------------------------------------
package pq_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } sched_state_t;

    typedef enum logic {
        OP_INS,
        OP_REM
    } pq_op_t;

endpackage

// File: rtl/pq_lvl_counter.sv
// -----------------------------------------------------------------------------
// pq_lvl_counter
//   Loadable level counter used to walk an operation through the queue levels.
//   Ports:
//     clk     : rising-edge clock
//     rst_n   : asynchronous active-low reset (counter -> 0)
//     i_load  : synchronous load of level 1 (has priority over i_inc)
//     i_inc   : increment by one
//     i_last  : terminal level of the current sweep
//     o_lvl   : current level
//     o_term  : o_lvl == i_last
// -----------------------------------------------------------------------------
module pq_lvl_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_inc,
    input  logic [W-1:0] i_last,
    output logic [W-1:0] o_lvl,
    output logic         o_term
);

    logic [W-1:0] r_lvl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lvl <= '0;
        end else if (i_load) begin
            r_lvl <= W'(1);
        end else if (i_inc) begin
            r_lvl <= r_lvl + 1'b1;
        end
    end

    assign o_lvl  = r_lvl;
    assign o_term = (r_lvl == i_last);

endmodule

// File: rtl/pq_op_sched.sv
// -----------------------------------------------------------------------------
// pq_op_sched
//   Operation scheduler for the systolic priority queue. Arbitrates insert and
//   remove requests round-robin, gates them against full/empty, then drives the
//   granted operation through the comparison levels one level per cycle.
//   Parameters:
//     W       : level-index width
//     LEVELS  : queue capacity, 1 <= LEVELS <= 2^W-1
//   Ports:
//     clk, rst_n        : clock, asynchronous active-low reset
//     ins_req / rem_req : level-held requests
//     cmp_stall         : datapath not ready, hold current level
//     ins_ack / rem_ack : one-cycle grant pulses
//     op, lvl, lvl_vld  : operation / level presented to the datapath
//     done              : one-cycle completion pulse
//     busy              : FSM not idle
//     count, full, empty: occupancy and its decodes
//   Configuration macro:
//     PQ_SCHED_EARLY_TERM_EN : sweep only the occupied levels
//       (insert: last = count+1, remove: last = count, sampled at grant)
// -----------------------------------------------------------------------------
module pq_op_sched
    import pq_sched_pkg::*;
#(
    parameter int unsigned W      = 4,
    parameter int unsigned LEVELS = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ins_req,
    input  logic         rem_req,
    input  logic         cmp_stall,
    output logic         ins_ack,
    output logic         rem_ack,
    output logic         op,
    output logic [W-1:0] lvl,
    output logic         lvl_vld,
    output logic         done,
    output logic         busy,
    output logic [W-1:0] count,
    output logic         full,
    output logic         empty
);

    localparam logic [W-1:0] LP_LEVELS = W'(LEVELS);

    sched_state_t r_state;
    sched_state_t w_next;
    pq_op_t       r_op;
    pq_op_t       r_last_grant;
    logic [W-1:0] r_count;
    logic         r_ins_ack;
    logic         r_rem_ack;

    logic         w_ins_elig;
    logic         w_rem_elig;
    logic         w_grant_ins;
    logic         w_grant_rem;
    logic         w_cnt_load;
    logic         w_cnt_inc;
    logic         w_term;
    logic         w_finish;
    logic [W-1:0] w_last;
    logic [W-1:0] w_lvl;

    assign full       = (r_count == LP_LEVELS);
    assign empty      = (r_count == '0);
    assign w_ins_elig = ins_req && !full;
    assign w_rem_elig = rem_req && !empty;

    // Last unstalled cycle of a sweep: FSM moves to DONE, occupancy updates.
    assign w_finish = (r_state == SWEEP) && !cmp_stall && w_term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_grant_ins = 1'b0;
        w_grant_rem = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            IDLE: begin
                // On a tie the type not granted last wins.
                if (w_ins_elig && (!w_rem_elig || r_last_grant == OP_REM)) begin
                    w_grant_ins = 1'b1;
                end else if (w_rem_elig) begin
                    w_grant_rem = 1'b1;
                end
                if (w_grant_ins || w_grant_rem) begin
                    w_cnt_load = 1'b1;
                    w_next     = SWEEP;
                end
            end
            SWEEP: begin
                if (!cmp_stall) begin
                    if (w_term) begin
                        w_next = DONE;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op         <= OP_INS;
            r_last_grant <= OP_REM;
            r_ins_ack    <= 1'b0;
            r_rem_ack    <= 1'b0;
            r_count      <= '0;
        end else begin
            r_ins_ack <= w_grant_ins;
            r_rem_ack <= w_grant_rem;
            if (w_grant_ins) begin
                r_op         <= OP_INS;
                r_last_grant <= OP_INS;
            end else if (w_grant_rem) begin
                r_op         <= OP_REM;
                r_last_grant <= OP_REM;
            end
            if (w_finish) begin
                if (r_op == OP_INS) begin
                    r_count <= r_count + 1'b1;
                end else begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

`ifdef PQ_SCHED_EARLY_TERM_EN
    logic [W-1:0] r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= '0;
        end else if (w_grant_ins) begin
            r_last <= r_count + 1'b1;
        end else if (w_grant_rem) begin
            r_last <= r_count;
        end
    end

    assign w_last = r_last;
`else
    assign w_last = LP_LEVELS;
`endif

    pq_lvl_counter #(
        .W (W)
    ) u_lvl_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_cnt_load),
        .i_inc  (w_cnt_inc),
        .i_last (w_last),
        .o_lvl  (w_lvl),
        .o_term (w_term)
    );

    assign lvl     = w_lvl;
    assign op      = r_op;
    assign ins_ack = r_ins_ack;
    assign rem_ack = r_rem_ack;
    assign lvl_vld = (r_state == SWEEP);
    assign done    = (r_state == DONE);
    assign busy    = (r_state != IDLE);
    assign count   = r_count;

endmodule

// File: tb/tb_pq_op_sched.sv
// -----------------------------------------------------------------------------
// tb_pq_op_sched
//   Directed bench for pq_op_sched (W=4, LEVELS=15, early termination off).
// -----------------------------------------------------------------------------
module tb_pq_op_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ins_req;
    logic       rem_req;
    logic       cmp_stall;
    logic       ins_ack;
    logic       rem_ack;
    logic       op;
    logic [3:0] lvl;
    logic       lvl_vld;
    logic       done;
    logic       busy;
    logic [3:0] count;
    logic       full;
    logic       empty;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pq_op_sched #(
        .W      (4),
        .LEVELS (15)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ins_req   (ins_req),
        .rem_req   (rem_req),
        .cmp_stall (cmp_stall),
        .ins_ack   (ins_ack),
        .rem_ack   (rem_ack),
        .op        (op),
        .lvl       (lvl),
        .lvl_vld   (lvl_vld),
        .done      (done),
        .busy      (busy),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        chk(tag, 32'(seen), 1);
    endtask

    // Raise one request, wait (bounded) for its ack, drop it, run to done,
    // check the resulting occupancy and step back to IDLE.
    task automatic do_op(input bit is_ins, input int exp_cnt);
        bit seen;
        seen = 1'b0;
        if (is_ins) ins_req = 1'b1;
        else        rem_req = 1'b1;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if ((is_ins ? ins_ack : rem_ack) === 1'b1) seen = 1'b1;
        end
        chk(is_ins ? "op_ins_ack" : "op_rem_ack", 32'(seen), 1);
        if (is_ins) ins_req = 1'b0;
        else        rem_req = 1'b0;
        wait_done("op_done");
        chk("op_count", 32'(count), 32'(exp_cnt));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        ins_req   = 1'b0;
        rem_req   = 1'b0;
        cmp_stall = 1'b0;
        #12;
        chk("rst_count",   32'(count),   0);
        chk("rst_lvl",     32'(lvl),     0);
        chk("rst_op",      32'(op),      0);
        chk("rst_lvl_vld", 32'(lvl_vld), 0);
        chk("rst_done",    32'(done),    0);
        chk("rst_busy",    32'(busy),    0);
        chk("rst_ins_ack", 32'(ins_ack), 0);
        chk("rst_rem_ack", 32'(rem_ack), 0);
        chk("rst_empty",   32'(empty),   1);
        chk("rst_full",    32'(full),    0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Remove held while empty: held off, never acked.
        rem_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("empty_rem_ack",  32'(rem_ack), 0);
            chk("empty_rem_busy", 32'(busy),    0);
        end

        // Insert at cycle t: full timeline, remove still pending.
        ins_req = 1'b1;
        tick();
        chk("t1_ins_ack", 32'(ins_ack), 1);
        chk("t1_rem_ack", 32'(rem_ack), 0);
        chk("t1_lvl",     32'(lvl),     1);
        chk("t1_lvl_vld", 32'(lvl_vld), 1);
        chk("t1_op",      32'(op),      0);
        chk("t1_busy",    32'(busy),    1);
        ins_req = 1'b0;
        for (int k = 2; k <= 15; k++) begin
            tick();
            chk("sweep_lvl", 32'(lvl), 32'(k));
            chk("sweep_vld", 32'(lvl_vld), 1);
            chk("sweep_done_low", 32'(done), 0);
        end
        tick();
        chk("t16_done",    32'(done),    1);
        chk("t16_lvl_vld", 32'(lvl_vld), 0);
        chk("t16_count",   32'(count),   1);
        chk("t16_empty",   32'(empty),   0);
        tick();
        chk("t17_busy", 32'(busy), 0);
        chk("t17_done", 32'(done), 0);
        tick();
        chk("t18_rem_ack", 32'(rem_ack), 1);
        chk("t18_op",      32'(op),      1);
        chk("t18_lvl",     32'(lvl),     1);
        rem_req = 1'b0;
        wait_done("rem_done");
        chk("rem_count", 32'(count), 0);
        chk("rem_empty", 32'(empty), 1);
        tick();

        // Fill to capacity.
        for (int i = 1; i <= 15; i++) do_op(1'b1, i);
        chk("fill_full",  32'(full),  1);
        chk("fill_count", 32'(count), 15);
        chk("fill_empty", 32'(empty), 0);

        // Insert at full is held off until a remove completes.
        ins_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("full_ins_ack",  32'(ins_ack), 0);
            chk("full_ins_busy", 32'(busy),    0);
        end
        rem_req = 1'b1;
        tick();
        chk("full_rem_ack", 32'(rem_ack), 1);
        chk("full_ins_nak", 32'(ins_ack), 0);
        rem_req = 1'b0;
        wait_done("full_rem_done");
        chk("full_rem_count", 32'(count), 14);
        chk("full_rem_full",  32'(full),  0);
        tick();
        tick();
        chk("held_ins_ack", 32'(ins_ack), 1);
        ins_req = 1'b0;
        wait_done("held_ins_done");
        chk("held_ins_count", 32'(count), 15);
        chk("held_ins_full",  32'(full),  1);
        tick();

        // Round-robin ties.
        do_op(1'b0, 14);
        do_op(1'b0, 13);
        ins_req = 1'b1;
        rem_req = 1'b1;
        tick();
        chk("tie1_ins_ack", 32'(ins_ack), 1);
        chk("tie1_rem_ack", 32'(rem_ack), 0);
        ins_req = 1'b0;
        wait_done("tie1_done");
        chk("tie1_count", 32'(count), 14);
        ins_req = 1'b1;
        tick();
        tick();
        chk("tie2_rem_ack", 32'(rem_ack), 1);
        chk("tie2_ins_ack", 32'(ins_ack), 0);
        rem_req = 1'b0;
        wait_done("tie2_done");
        chk("tie2_count", 32'(count), 13);
        tick();
        tick();
        chk("tie3_ins_ack", 32'(ins_ack), 1);
        ins_req = 1'b0;
        wait_done("tie3_done");
        chk("tie3_count", 32'(count), 14);
        tick();

        // Three stall cycles at level 7 delay done to t+19.
        rem_req = 1'b1;
        tick();
        chk("stall_rem_ack", 32'(rem_ack), 1);
        chk("stall_lvl1",    32'(lvl),     1);
        rem_req = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("stall_lvl7", 32'(lvl), 7);
        cmp_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold_lvl", 32'(lvl),     7);
            chk("stall_hold_vld", 32'(lvl_vld), 1);
            chk("stall_hold_op",  32'(op),      1);
        end
        cmp_stall = 1'b0;
        for (int k = 8; k <= 15; k++) begin
            tick();
            chk("stall_post_lvl", 32'(lvl), 32'(k));
            chk("stall_post_done_low", 32'(done), 0);
        end
        tick();
        chk("stall_t19_done",  32'(done),  1);
        chk("stall_t19_count", 32'(count), 13);
        tick();

        // Asynchronous reset in the middle of a sweep.
        ins_req = 1'b1;
        tick();
        chk("ar_ins_ack", 32'(ins_ack), 1);
        ins_req = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("ar_lvl9", 32'(lvl), 9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_lvl",     32'(lvl),     0);
        chk("ar_lvl_vld", 32'(lvl_vld), 0);
        chk("ar_busy",    32'(busy),    0);
        chk("ar_done",    32'(done),    0);
        chk("ar_op",      32'(op),      0);
        chk("ar_count",   32'(count),   0);
        chk("ar_empty",   32'(empty),   1);
        chk("ar_full",    32'(full),    0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("ar_post_busy",  32'(busy),  0);
        chk("ar_post_count", 32'(count), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pq_op_sched.md
# pq_op_sched

Operation scheduler for the systolic priority queue. Accepts insert and remove requests from two requesters and arbitrates between them round-robin. Each granted operation is driven through the queue's comparison levels one level per cycle, using a loadable level counter. The block also tracks occupancy and gates requests against full and empty, so the comparison datapath only ever sees one legal operation at a time.

## Interface
- `W`, default 4: level-index width.
- `LEVELS`, default 15: number of queue levels (capacity). Must satisfy 1 ≤ LEVELS ≤ 2^W−1.
- `clk` input, 1: rising-edge clock.
- `rst_n` input, 1: reset. Asynchronous, active-low.
- `ins_req` input, 1: insert request. Level-held until `ins_ack`.
- `rem_req` input, 1: remove request. Level-held until `rem_ack`.
- `cmp_stall` input, 1: datapath not ready. Holds the current level.
- `ins_ack` output, 1: one-cycle pulse when an insert is granted.
- `rem_ack` output, 1: one-cycle pulse when a remove is granted.
- `op` output, 1: current operation (0 = insert, 1 = remove). Valid while `lvl_vld` is high.
- `lvl` output, W: level being compared.
- `lvl_vld` output, 1: `lvl`/`op` valid for the datapath.
- `done` output, 1: one-cycle pulse when the operation completes.
- `busy` output, 1: state is not IDLE.
- `count` output, W: current occupancy.
- `full` output, 1: `count == LEVELS`.
- `empty` output, 1: `count == 0`.

## Operation
- FSM states and transitions:
  - IDLE → SWEEP on a grant.
  - SWEEP → DONE on an unstalled cycle with `lvl == last`.
  - DONE → IDLE unconditionally.
- Eligibility:
  - Insert is eligible when `ins_req && !full`.
  - Remove is eligible when `rem_req && !empty`.
  - Ineligible requests are held off, never dropped or acked.
- Arbitration:
  - With a single eligible request, grant it.
  - With both eligible, grant the type not granted last.
  - The `last_grant` register resets to remove, so insert wins the first tie.
- Grant actions (registered):
  - Load the level counter to 1.
  - Latch `op`.
  - Pulse the matching ack.
- SWEEP:
  - `lvl_vld = 1`.
  - `lvl` increments by 1 each cycle with `cmp_stall = 0`.
  - With `cmp_stall = 1`, `lvl`, `op` and `lvl_vld` are held.
- Termination level `last` is LEVELS, except as modified under Configuration.
- DONE:
  - `done = 1`, `lvl_vld = 0`.
  - `count` increments (insert) or decrements (remove), registered and visible the same cycle `done` is high.
- Requests are ignored in SWEEP and DONE. A requester must drop its request in the cycle after its ack; a request still high in IDLE is treated as a new request.
- `count` never wraps, because eligibility prevents insert at full and remove at empty.
- `lvl` never exceeds `last`. There is no wrap to 0 during a sweep.

## Timing
- Reset values (while `rst_n` low, immediately and asynchronously):
  - State IDLE.
  - `count = 0`, `lvl = 0`, `op = 0`.
  - All acks, `lvl_vld`, `done` and `busy` at 0.
  - `empty = 1`, `full = 0`.
- Reset mid-sweep abandons the operation and does not change `count` beyond clearing it.
- Cycle timeline for a request sampled in IDLE at cycle t, with no stalls:
  - t+1: ack, `lvl = 1`, `lvl_vld`.
  - t+k: `lvl = k`.
  - t+last+1: `done`.
  - t+last+2: IDLE.
- Each stall cycle delays every subsequent event by one cycle.
- Minimum spacing between grants is `last + 2` cycles.
- `full` and `empty` are decoded combinationally from the registered `count`.

## Configuration
- `PQ_SCHED_EARLY_TERM_EN` defined: sweeps cover only the occupied levels.
  - Insert: `last = count + 1`.
  - Remove: `last = count`.
  - `count` is sampled at the grant.
- `PQ_SCHED_EARLY_TERM_EN` undefined: `last = LEVELS` for every operation.

## Structure
- Package `pq_sched_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, SWEEP, DONE} sched_state_t`.
  - `typedef enum logic {OP_INS, OP_REM} pq_op_t`.
- Sub-module `pq_lvl_counter`, parameter W, with:
  - Synchronous load-to-1, increment enable and compare-to-`last` terminal flag.
  - Asynchronous active-low reset to 0.
- The FSM, arbiter and occupancy counter stay in `pq_op_sched`.

## Test plan
All scenarios use W=4, LEVELS=15, macro undefined unless stated.
- Reset, then `ins_req` at cycle t → `ins_ack` at t+1; `lvl` = 1..15 on t+1..t+15; `done` at t+16; `count = 1`; `empty = 0`.
- `rem_req` held with `count = 0` → no ack, `busy = 0` for 20 cycles. A following insert completes, then the remove is granted.
- Both requests high from reset → insert granted first, remove granted second at t+17. `count` returns to 0.
- 15 inserts → `full = 1`. A further `ins_req` is not acked until a remove completes.
- `cmp_stall` high for 3 cycles at `lvl = 7` → `lvl` holds 7 for 4 cycles; `done` moves to t+19. Separately, `rst_n` low at `lvl = 9` → all outputs cleared asynchronously and `count = 0`.
- Macro defined, `count = 3`, remove granted → `lvl` = 1..3, `done` at t+4, `count = 2`.
